apb_regbank_slave: RTL and testbench
====================================

# apb_regbank_slave

APB3 completer holding the student-record register bank (group number, date, surname, name) plus a transfer counter and an ID word. Sits on the bus opposite the `master` initiator and answers its setup/access transfers. Inserts a configurable number of wait states, and flags bad accesses on PSLVERR.

## Interface
Parameters:
- WAIT_STATES, 1, access-phase cycles with PREADY low before completion (legal 0..7)
- ID_VALUE, 32'h4C414231, constant returned at address 0x14

Ports:
- PCLK  in  1  bus clock; all state updates on rising edge
- PRESET  in  1  reset, synchronous, active-high
- PSEL  in  1  completer select
- PENABLE  in  1  access-phase marker
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address
- PWDATA  in  32  write data
- PRDATA  out  32  read data, registered
- PREADY  out  1  transfer completes in the cycle it is high, registered
- PSLVERR  out  1  error response, valid only while PREADY high, registered

## Operation
- Address map, word-aligned:
  - 0x00 NUM, R/W
  - 0x04 DATE, R/W
  - 0x08 SURNAME, R/W
  - 0x0C NAME, R/W
  - 0x10 CNT, read returns {16'h0, cnt[15:0]}; any write clears cnt, not an error
  - 0x14 ID, read-only
- Error conditions:
  - PADDR[1:0] != 0
  - PADDR > 0x14
  - write to 0x14
- Errored write changes no register. Errored read returns PRDATA = 0.
- FSM states:
  - IDLE
  - WAIT, counting down
  - DONE, PREADY high
- IDLE -> WAIT: PSEL=1 and PENABLE=0 sampled at a rising edge (setup phase). Latches PADDR, PWRITE, PWDATA. Loads wait counter with WAIT_STATES.
- WAIT: while counter != 0, decrement each edge, PREADY=0.
  - When counter reaches 0 (or immediately if WAIT_STATES=0), drive PRDATA and PSLVERR and go to DONE.
- DONE: PREADY=1 for exactly one cycle. On the closing edge:
  - commit the write using latched address and data
  - cnt += 1 if no error
  - PREADY, PSLVERR <= 0
  - return to IDLE, or straight to WAIT if a new setup phase is sampled on that same edge
- PSEL falls while in WAIT: abort, return to IDLE, no write, cnt unchanged, PREADY stays 0.
- cnt is 16-bit and wraps 0xFFFF -> 0x0000. A write to 0x10 clears cnt. The clear is not itself counted: cnt reads 0 afterwards.
- PRDATA holds its last value outside DONE. It is cleared only by reset.

## Timing
- Reset (PRESET=1 at an edge):
  - PRDATA=0, PREADY=0, PSLVERR=0, cnt=0
  - all four R/W registers = 0
  - state IDLE
- Reset has priority over everything. Reset asserted mid-transfer aborts it with no register write.
- Setup cycle T0, access cycles start at T1. PREADY is high during cycle T1+WAIT_STATES.
  - With WAIT_STATES=1, PREADY is high in T2, i.e. a 3-cycle transfer.
- Read data is visible in the PREADY-high cycle. Write data is visible in the register from the cycle after PREADY.
- PWDATA and PADDR changes after T0 are ignored, because latched copies are used.
- Back-to-back: a new setup in the cycle after DONE is accepted with no idle cycle.

## Configuration
- APB_REGBANK_PSLVERR_EN defined: error conditions assert PSLVERR together with PREADY.
- Not defined:
  - PSLVERR is tied to 0
  - errored accesses complete silently: writes are dropped, reads return 0
  - cnt still does not count them

## Test plan
- Reset, then read 0x00..0x0C -> all 0, PSLVERR=0, PREADY high exactly in T2 with WAIT_STATES=1.
- Write 6 to 0x00, 32'h20122023 to 0x04, 32'h44726F62 to 0x08, 32'h56657261 to 0x0C, then read all four back -> identical values; CNT read -> 8 (the 8 prior transfers: 4 writes plus 4 reads).
- Read 0x14 -> ID_VALUE. Write 0x14, read 0x02, read 0x18 -> PSLVERR=1 each, PRDATA=0 on the reads, cnt unchanged. With the macro undefined, PSLVERR stays 0.
- Drop PSEL in T1 of a write to 0x04 (WAIT_STATES=2) -> no PREADY, 0x04 unchanged, cnt unchanged. A following transfer completes normally.
- Assert PRESET during the WAIT cycle of a write to 0x08 -> register stays 0, all outputs 0 on the next cycle.
- Preload cnt to 0xFFFF via 65535 reads, then one more read -> CNT read returns 0x0000. Write 0x10 -> next CNT read returns 0.

Source files
------------

// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB3 completer for the student-record bank with wait states; define APB_REGBANK_PSLVERR_EN to report bad accesses on PSLVERR
module apb_regbank_slave #(
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] ID_VALUE    = 32'h4C414231
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   localparam logic [2:0] WS = 3'(WAIT_STATES);
   state_t      state, state_nx;
   logic [2:0]  wcnt, wcnt_nx;
   logic [31:0] addr_q, wdata_q;
   logic        write_q, err_q;
   logic [31:0] reg_num, reg_date, reg_surname, reg_name;
   logic [15:0] cnt;
   logic        setup, complete, acc_write, acc_err;
   logic [31:0] acc_addr, rdata;
   // Next state; a setup seen in DONE chains straight into the next transfer, PSEL dropping in WAIT aborts.
   always_comb begin
      setup    = PSEL && !PENABLE;
      state_nx = state;
      wcnt_nx  = wcnt;
      complete = 1'b0;
      case (state)
         WAIT: begin
            state_nx = !PSEL ? IDLE : (wcnt <= 3'd1) ? DONE : WAIT;
            wcnt_nx  = (!PSEL || wcnt <= 3'd1) ? 3'd0 : wcnt - 3'd1;
            complete = PSEL && wcnt <= 3'd1;
         end
         default: begin
            state_nx = setup ? ((WS == 3'd0) ? DONE : WAIT) : IDLE;
            wcnt_nx  = setup ? WS : wcnt;
            complete = setup && (WS == 3'd0);
         end
      endcase
   end
   // Decode the completing access: live bus for a zero-wait setup, latched copy otherwise.
   always_comb begin
      acc_addr  = (state == WAIT) ? addr_q : PADDR;
      acc_write = (state == WAIT) ? write_q : PWRITE;
      acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr > 32'h14) || (acc_write && acc_addr == 32'h14);
      case (acc_addr[4:2])
         3'd0:    rdata = reg_num;
         3'd1:    rdata = reg_date;
         3'd2:    rdata = reg_surname;
         3'd3:    rdata = reg_name;
         3'd4:    rdata = {16'h0, cnt};
         3'd5:    rdata = ID_VALUE;
         default: rdata = 32'h0;
      endcase
   end
   // State register and wait counter.
   always_ff @(posedge PCLK) begin
      state <= PRESET ? IDLE : state_nx;
      wcnt  <= PRESET ? 3'd0 : wcnt_nx;
   end
   // Capture the setup phase so later bus changes cannot disturb the transfer.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         write_q <= 1'b0;
      end else if (setup && state != WAIT) begin
         addr_q  <= PADDR;
         wdata_q <= PWDATA;
         write_q <= PWRITE;
      end
   end
   // Response registers: PREADY/error pulse for the DONE cycle, PRDATA only moves on a completing read.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         PREADY <= 1'b0;
         err_q  <= 1'b0;
         PRDATA <= 32'h0;
      end else begin
         PREADY <= complete;
         err_q  <= complete && acc_err;
         if (complete && !acc_write) PRDATA <= acc_err ? 32'h0 : rdata;
      end
   end
   // Commit on the closing edge of DONE; a CNT write clears the counter instead of counting itself.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         reg_num     <= 32'h0;
         reg_date    <= 32'h0;
         reg_surname <= 32'h0;
         reg_name    <= 32'h0;
         cnt         <= 16'h0;
      end else if (state == DONE && !err_q) begin
         if (write_q && addr_q[4:2] == 3'd0) reg_num <= wdata_q;
         if (write_q && addr_q[4:2] == 3'd1) reg_date <= wdata_q;
         if (write_q && addr_q[4:2] == 3'd2) reg_surname <= wdata_q;
         if (write_q && addr_q[4:2] == 3'd3) reg_name <= wdata_q;
         cnt <= (write_q && addr_q[4:2] == 3'd4) ? 16'h0 : cnt + 16'h1;
      end
   end
`ifdef APB_REGBANK_PSLVERR_EN
   assign PSLVERR = err_q;
`else
   assign PSLVERR = 1'b0;
`endif
endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb_apb_regbank_slave: directed APB transfers on completers with 1, 2 and 0 wait states, checked against a register model
`timescale 1ns/1ps
module tb_apb_regbank_slave;
   localparam logic [31:0] ID = 32'h4C414231;
   localparam int NS = 65534;
`ifdef APB_REGBANK_PSLVERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   typedef struct {int d; int c; bit rd; bit err; logic [31:0] data;} exp_t;
   logic        PCLK = 1'b0, PRESET = 1'b1, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0] PADDR = 32'h0, PWDATA = 32'h0;
   logic [2:0]  psel = 3'b0, pready, pslverr;
   logic [31:0] prdata [3];
   int          total = 0, bad = 0, cyc = 0;
   bit          chk_on = 1'b0;
   exp_t        eq[$];
   logic [31:0] mreg [3][4];
   logic [15:0] mcnt [3];
   logic [31:0] exp_prdata [3];

   apb_regbank_slave #(.WAIT_STATES(1)) u0 (.PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
   apb_regbank_slave #(.WAIT_STATES(2)) u1 (.PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
   apb_regbank_slave #(.WAIT_STATES(0)) u2 (.PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   function automatic int ws_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 2 : 0;
   endfunction
   function automatic bit m_err(input bit w, input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a > 32'h14) || (w && a == 32'h14);
   endfunction
   function automatic logic [31:0] m_read(input int d, input logic [31:0] a);
      if (m_err(1'b0, a)) return 32'h0;
      if (a < 32'h10) return mreg[d][a[3:2]];
      return (a == 32'h10) ? {16'h0, mcnt[d]} : ID;
   endfunction
   function automatic void m_commit(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
      if (m_err(w, a)) return;
      if (w && a == 32'h10) mcnt[d] = 16'h0;
      else begin
         mcnt[d] = mcnt[d] + 16'h1;
         if (w && a < 32'h10) mreg[d][a[3:2]] = wd;
      end
   endfunction
   function automatic void m_reset();
      for (int d = 0; d < 3; d++) begin
         mcnt[d] = 16'h0;
         exp_prdata[d] = 32'h0;
         for (int r = 0; r < 4; r++) mreg[d][r] = 32'h0;
      end
      eq.delete();
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s dut%0d: got %h want %h (cycle %0d)", nm, d, act, want, cyc);
      end
   endtask

   // Every cycle: PREADY only in the predicted cycle, PSLVERR with it on errors, PRDATA holding the last read.
   always @(negedge PCLK) begin
      if (chk_on) begin
         for (int d = 0; d < 3; d++) begin
            bit due;
            due = eq.size() > 0 && eq[0].d == d && eq[0].c == cyc;
            if (due && eq[0].rd) exp_prdata[d] = eq[0].data;
            chk("PREADY", d, {31'h0, pready[d]}, {31'h0, due});
            chk("PSLVERR", d, {31'h0, pslverr[d]}, {31'h0, due && eq[0].err && ERR_EN});
            chk("PRDATA", d, prdata[d], exp_prdata[d]);
         end
         while (eq.size() > 0 && eq[0].c <= cyc) void'(eq.pop_front());
      end
   end

   task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat);
      exp_t e;
      int   t0, n;
      bit   ok;
      t0 = cyc;
      e.d = d; e.c = t0 + 1 + ws_of(d); e.rd = !w; e.err = m_err(w, a); e.data = m_read(d, a);
      eq.push_back(e);
      psel = 3'b0; psel[d] = 1'b1;
      PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; PADDR = a ^ 32'h8; PWDATA = ~wd;
      n = 0;
      while (!pready[d] && n < 16) begin
         @(posedge PCLK); #1;
         n++;
      end
      ok = pready[d]; rd = prdata[d]; err = pslverr[d]; lat = cyc - t0;
      if (!ok) chk("timeout", d, 32'h0, 32'h1);
      @(posedge PCLK); #1;
      if (ok) m_commit(d, w, a, wd);
      psel = 3'b0; PENABLE = 1'b0;
   endtask
   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] r; logic e; int l;
      xfer(d, 1'b1, a, wd, r, e, l);
   endtask
   task automatic rd_pin(input int d, input logic [31:0] a, input logic [31:0] want, input string nm);
      logic [31:0] r; logic e; int l;
      xfer(d, 1'b0, a, 32'h0, r, e, l);
      chk(nm, d, r, want);
   endtask
   task automatic do_reset();
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      m_reset();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic        e;
      int          l;
      m_reset();
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1'b0;
      chk_on = 1'b1;
      xfer(0, 1'b0, 32'h0, 32'h0, r, e, l);
      chk("lat_ws1", 0, l, 2);
      chk("rst_num", 0, r, 32'h0);
      chk("rst_err", 0, 32'(e), 32'h0);
      for (int a = 4; a < 16; a += 4) rd_pin(0, a, 32'h0, "rst_reg");
      do_reset();
      wr(0, 32'h00, 32'd6);
      wr(0, 32'h04, 32'h20122023);
      wr(0, 32'h08, 32'h44726F62);
      wr(0, 32'h0C, 32'h56657261);
      rd_pin(0, 32'h00, 32'd6, "num");
      rd_pin(0, 32'h04, 32'h20122023, "date");
      rd_pin(0, 32'h08, 32'h44726F62, "surname");
      rd_pin(0, 32'h0C, 32'h56657261, "name");
      rd_pin(0, 32'h10, 32'd8, "cnt8");
      rd_pin(0, 32'h14, ID, "id");
      xfer(0, 1'b1, 32'h14, 32'hFFFF_FFFF, r, e, l);
      chk("err_wr_id", 0, 32'(e), 32'(ERR_EN));
      xfer(0, 1'b0, 32'h02, 32'h0, r, e, l);
      chk("err_misalign", 0, 32'(e), 32'(ERR_EN));
      chk("err_misalign_data", 0, r, 32'h0);
      xfer(0, 1'b0, 32'h18, 32'h0, r, e, l);
      chk("err_range", 0, 32'(e), 32'(ERR_EN));
      chk("err_range_data", 0, r, 32'h0);
      rd_pin(0, 32'h10, 32'd10, "cnt_err");
      xfer(1, 1'b1, 32'h04, 32'h11112222, r, e, l);
      chk("lat_ws2", 1, l, 3);
      psel = 3'b010; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'hBAD0BAD0;
      @(posedge PCLK); #1;
      psel = 3'b000; PENABLE = 1'b1;
      repeat (3) begin
         @(posedge PCLK); #1;
      end
      PENABLE = 1'b0;
      rd_pin(1, 32'h04, 32'h11112222, "abort_keep");
      rd_pin(1, 32'h10, 32'd2, "abort_cnt");
      psel = 3'b001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'hCAFEF00D;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; PRESET = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b0; psel = 3'b000; PENABLE = 1'b0;
      m_reset();
      chk("rst_mid_ready", 0, 32'(pready[0]), 32'h0);
      chk("rst_mid_rdata", 0, prdata[0], 32'h0);
      rd_pin(0, 32'h08, 32'h0, "rst_mid_reg");
      xfer(2, 1'b1, 32'h00, 32'hA5, r, e, l);
      chk("lat_ws0", 2, l, 1);
      psel = 3'b100; PWRITE = 1'b0; PADDR = 32'h0;
      for (int i = 0; i < NS; i++) begin
         exp_t s;
         s.d = 2; s.c = cyc + 1; s.rd = 1'b1; s.err = 1'b0; s.data = m_read(2, 32'h0);
         eq.push_back(s);
         PENABLE = 1'b0;
         @(posedge PCLK); #1;
      end
      psel = 3'b000;
      @(posedge PCLK); #1;
      mcnt[2] = mcnt[2] + 16'(NS);
      rd_pin(2, 32'h10, 32'h0000FFFF, "cnt_ffff");
      rd_pin(2, 32'h10, 32'h0, "cnt_wrap");
      rd_pin(2, 32'h00, 32'hA5, "num_ws0");
      wr(2, 32'h10, 32'h1234);
      rd_pin(2, 32'h10, 32'h0, "cnt_clr");
      rd_pin(2, 32'h10, 32'h1, "cnt_after_clr");
      @(posedge PCLK); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
